// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline MEM stage; drives one req/addr_ok/data_ok SRAM
//               transaction at a time and hands results to WB.
// Revision    : 1.0
// ============================================================================
module mem_access_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic [110:0] EX_to_MEM_bus,
    input  logic         EX_to_MEM_valid,
    output logic         MEM_allow_in,
    output logic         MEM_to_WB_valid,
    input  logic         WB_allow_in,
    output logic [112:0] MEM_to_WB_bus,
    output logic [39:0]  MEM_to_BY_bus,
    output logic         data_sram_req,
    output logic         data_sram_wr,
    output logic [3:0]   data_sram_wstrb,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    input  logic         data_sram_addr_ok,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_valid;
    logic [110:0]  r_bus;
    logic [31:0]   r_rdata_buf;

    logic          w_new_instr;
    logic          w_capture;
    logic          w_mem_op;
    logic          w_in_mem_op;
    logic          w_ready_go;
    logic [3:0]    w_byte_en;
    logic [3:0]    w_in_byte_en;

    // Staged instruction fields
    logic [2:0]    w_stage;
    logic          w_sel_en;
    logic          w_sel_data;
    logic [1:0]    w_wd;
    logic          w_ext;
    logic          w_re;
    logic          w_we;
    logic [31:0]   w_store_data;
    logic [4:0]    w_waddr;
    logic [31:0]   w_alu;
    logic [31:0]   w_pc;
    logic [31:0]   w_fwd_data;
    logic          w_fwd_valid;

    // Zero result means the access is misaligned for its width.
    function automatic logic [3:0] f_byte_en(input logic [1:0] wd, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        if (wd[1]) begin
            case (lo)
                2'd0: be = 4'b0001;
                2'd1: be = 4'b0010;
                2'd2: be = 4'b0100;
                2'd3: be = 4'b1000;
            endcase
        end else if (wd[0]) begin
            if (!lo[0]) begin
                be = lo[1] ? 4'b1100 : 4'b0011;
            end
        end else if (lo == 2'b00) begin
            be = 4'b1111;
        end
        return be;
    endfunction

    assign w_stage      = r_bus[110:108];
    assign w_sel_en     = r_bus[107];
    assign w_sel_data   = r_bus[106];
    assign w_wd         = r_bus[105:104];
    assign w_ext        = r_bus[103];
    assign w_re         = r_bus[102];
    assign w_we         = r_bus[101];
    assign w_store_data = r_bus[100:69];
    assign w_waddr      = r_bus[68:64];
    assign w_alu        = r_bus[63:32];
    assign w_pc         = r_bus[31:0];

    assign w_byte_en    = f_byte_en(w_wd, w_alu[1:0]);
    assign w_mem_op     = r_valid & (w_re | w_we) & (w_byte_en != 4'b0000);

    // Decide the entry state from the incoming instruction itself.
    assign w_in_byte_en = f_byte_en(EX_to_MEM_bus[105:104], EX_to_MEM_bus[33:32]);
    assign w_in_mem_op  = (EX_to_MEM_bus[102] | EX_to_MEM_bus[101]) & (w_in_byte_en != 4'b0000);

    assign w_ready_go      = ~w_mem_op | (r_state == ST_DONE);
    assign MEM_allow_in    = ~r_valid | (w_ready_go & WB_allow_in);
    assign MEM_to_WB_valid = r_valid & w_ready_go;
    assign w_new_instr     = EX_to_MEM_valid & MEM_allow_in;

    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        data_sram_req = 1'b0;
        if (r_state == ST_WAIT_ADDR) begin
            data_sram_req = 1'b1;
        end
        if (w_new_instr) begin
            w_state_nxt = w_in_mem_op ? ST_WAIT_ADDR : ST_IDLE;
        end else begin
            case (r_state)
                ST_WAIT_ADDR: begin
                    if (data_sram_addr_ok) begin
                        w_state_nxt = ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (data_sram_data_ok) begin
                        w_state_nxt = ST_DONE;
                        w_capture   = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (WB_allow_in) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_bus       <= '0;
            r_rdata_buf <= 32'd0;
        end else begin
            if (MEM_allow_in) begin
                r_valid <= EX_to_MEM_valid;
            end
            if (w_new_instr) begin
                r_bus <= EX_to_MEM_bus;
            end
            if (w_capture) begin
                r_rdata_buf <= data_sram_rdata;
            end
        end
    end

    // Request fields come straight from the stage register, so they stay
    // stable for as long as the stage is stalled waiting on addr_ok.
    assign data_sram_addr  = {w_alu[31:2], 2'b00};
    assign data_sram_wr    = w_we;
    assign data_sram_wstrb = w_we ? w_byte_en : 4'b0000;

    always_comb begin
        if (w_wd[1]) begin
            data_sram_wdata = {4{w_store_data[7:0]}};
        end else if (w_wd[0]) begin
            data_sram_wdata = {2{w_store_data[15:0]}};
        end else begin
            data_sram_wdata = w_store_data;
        end
    end

    assign MEM_to_WB_bus = {w_stage, w_sel_en, w_sel_data, w_wd, w_ext,
                            w_byte_en, r_rdata_buf, w_waddr, w_alu, w_pc};

    assign w_fwd_data    = (w_waddr == 5'd0) ? 32'd0 : w_alu;
    assign w_fwd_valid   = r_valid & ~w_sel_data & (w_stage[0] | w_stage[1]);
    assign MEM_to_BY_bus = {w_waddr, w_fwd_data, w_fwd_valid, r_valid, w_sel_en};

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed and random stimulus for mem_access_stage against a
//               transaction-level reference of the MEM stage.
// Revision    : 1.0
// ============================================================================
module tb_mem_access_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic [110:0] EX_to_MEM_bus;
    logic         EX_to_MEM_valid;
    logic         MEM_allow_in;
    logic         MEM_to_WB_valid;
    logic         WB_allow_in;
    logic [112:0] MEM_to_WB_bus;
    logic [39:0]  MEM_to_BY_bus;
    logic         data_sram_req;
    logic         data_sram_wr;
    logic [3:0]   data_sram_wstrb;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         data_sram_addr_ok;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;

    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    logic [31:0] m_buf   = 32'd0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk               (clk),
        .reset             (reset),
        .EX_to_MEM_bus     (EX_to_MEM_bus),
        .EX_to_MEM_valid   (EX_to_MEM_valid),
        .MEM_allow_in      (MEM_allow_in),
        .MEM_to_WB_valid   (MEM_to_WB_valid),
        .WB_allow_in       (WB_allow_in),
        .MEM_to_WB_bus     (MEM_to_WB_bus),
        .MEM_to_BY_bus     (MEM_to_BY_bus),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    // Lanes touched by an access of the given width; zero when misaligned.
    function automatic logic [3:0] m_ben(input logic [1:0] wd, input logic [31:0] a);
        int ofs;
        ofs = int'(a[1:0]);
        if (wd[1]) return 4'(1 << ofs);
        if (wd[0]) return (ofs % 2 != 0) ? 4'd0 : 4'(3 << ofs);
        return (ofs == 0) ? 4'd15 : 4'd0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] wd, input logic [31:0] sd);
        if (wd[1]) return 32'(sd[7:0]) * 32'h0101_0101;
        if (wd[0]) return 32'(sd[15:0]) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [110:0] mk(input logic [2:0] stg, input logic en, input logic sdat,
                                        input logic [1:0] wd, input logic ext, input logic re,
                                        input logic we, input logic [31:0] sd, input logic [4:0] wa,
                                        input logic [31:0] alu, input logic [31:0] pc);
        return {stg, en, sdat, wd, ext, re, we, sd, wa, alu, pc};
    endfunction

    // Issues one instruction, plays the SRAM slave and WB, and checks every cycle
    // until the single handoff to WB.
    task automatic run_instr(input logic [110:0] ins, input bit rnd, input int aok_dly,
                             input int dok_dly, input int wb_stall, input logic [31:0] rdv,
                             output int lat, output logic [3:0] obs_wstrb,
                             output logic [31:0] obs_wdata, output logic [112:0] obs_wb);
        logic [1:0]   wd;
        logic         we;
        logic         mop;
        logic [31:0]  sd;
        logic [31:0]  alu;
        logic [4:0]   wa;
        logic [3:0]   ben;
        logic [39:0]  exp_by;
        logic [127:0] junk;
        int           phase;
        int           p0;
        int           p1;
        int           stalls;
        bit           done;
        bit           ereq;
        bit           ewbv;
        wd  = ins[105:104];
        we  = ins[101];
        sd  = ins[100:69];
        wa  = ins[68:64];
        alu = ins[63:32];
        ben = m_ben(wd, alu);
        mop = (ins[102] | we) && (ben != 4'd0);
        exp_by = {wa, (wa == 5'd0) ? 32'd0 : alu, ~ins[106] & (ins[108] | ins[109]), 1'b1, ins[107]};
        lat = -1; obs_wstrb = 4'd0; obs_wdata = 32'd0; obs_wb = '0;
        phase = 0; p0 = 0; p1 = 0; stalls = 0; done = 0;

        @(negedge clk);
        EX_to_MEM_bus     = ins;
        EX_to_MEM_valid   = 1'b1;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        WB_allow_in       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        chk("accept_allow", 128'(MEM_allow_in), 128'(1'b1));
        chk("idle_wb_valid", 128'(MEM_to_WB_valid), 128'(1'b0));
        chk("idle_req", 128'(data_sram_req), 128'(1'b0));

        for (int k = 1; k <= 64 && !done; k++) begin
            @(negedge clk);
            junk            = {$urandom, $urandom, $urandom, $urandom};
            EX_to_MEM_valid = 1'b0;
            EX_to_MEM_bus   = junk[110:0];
            ereq = mop && (phase == 0);
            ewbv = !mop || (phase == 2);
            if (rnd) begin
                data_sram_addr_ok = 1'($urandom_range(0, 1));
                data_sram_data_ok = 1'($urandom_range(0, 1));
                data_sram_rdata   = $urandom;
                WB_allow_in       = 1'($urandom_range(0, 1));
            end else begin
                data_sram_addr_ok = (phase == 0) && (p0 >= aok_dly);
                data_sram_data_ok = (phase == 1) && (p1 >= dok_dly);
                data_sram_rdata   = rdv;
                WB_allow_in       = !(ewbv && stalls < wb_stall);
            end
            #1;
            chk("req", 128'(data_sram_req), 128'(ereq));
            chk("wb_valid", 128'(MEM_to_WB_valid), 128'(ewbv));
            chk("allow_in", 128'(MEM_allow_in), 128'(ewbv && WB_allow_in));
            chk("sram_addr", 128'(data_sram_addr), 128'(alu & ~32'd3));
            chk("sram_wr", 128'(data_sram_wr), 128'(we));
            chk("sram_wstrb", 128'(data_sram_wstrb), 128'(we ? ben : 4'd0));
            chk("sram_wdata", 128'(data_sram_wdata), 128'(m_wdata(wd, sd)));
            chk("by_bus", 128'(MEM_to_BY_bus), 128'(exp_by));
            if (ewbv) begin
                chk("wb_bus", 128'(MEM_to_WB_bus),
                    128'({ins[110:103], ben, m_buf, wa, alu, ins[31:0]}));
            end
            if (k == 1) begin
                obs_wstrb = data_sram_wstrb;
                obs_wdata = data_sram_wdata;
            end
            if (MEM_to_WB_valid && lat < 0) lat = k;
            if (ewbv && WB_allow_in) begin
                done   = 1;
                obs_wb = MEM_to_WB_bus;
            end else if (mop && phase == 0) begin
                if (data_sram_addr_ok) phase = 1; else p0++;
            end else if (mop && phase == 1) begin
                if (data_sram_data_ok) begin
                    phase = 2;
                    m_buf = data_sram_rdata;
                end else begin
                    p1++;
                end
            end
            if (ewbv && !WB_allow_in) stalls++;
        end
        chk("handoff_in_budget", 128'(done), 128'(1'b1));

        @(negedge clk);
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        WB_allow_in       = 1'b1;
        #1;
        chk("after_handoff_wb_valid", 128'(MEM_to_WB_valid), 128'(1'b0));
        chk("after_handoff_allow", 128'(MEM_allow_in), 128'(1'b1));
        chk("after_handoff_req", 128'(data_sram_req), 128'(1'b0));
    endtask

    initial begin
        int           lat;
        logic [3:0]   ows;
        logic [31:0]  owd;
        logic [112:0] owb;
        logic [1:0]   wd;
        logic [1:0]   sel;
        logic [4:0]   wa;

        reset             = 1'b1;
        EX_to_MEM_bus     = '0;
        EX_to_MEM_valid   = 1'b0;
        WB_allow_in       = 1'b1;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_allow_in", 128'(MEM_allow_in), 128'(1'b1));
        chk("rst_wb_valid", 128'(MEM_to_WB_valid), 128'(1'b0));
        chk("rst_req", 128'(data_sram_req), 128'(1'b0));
        chk("rst_wstrb", 128'(data_sram_wstrb), 128'(4'd0));
        chk("rst_by_bus", 128'(MEM_to_BY_bus), 128'(40'd0));
        chk("rst_wb_bus", 128'(MEM_to_WB_bus), 128'({8'd0, m_ben(2'b00, 32'd0), 101'd0}));
        reset = 1'b0;

        // ld.w 0x1004, addr_ok with req, data_ok the following cycle
        run_instr(mk(3'b100, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'd0, 5'd5, 32'h0000_1004,
                     32'h1c00_0000), 0, 0, 0, 0, 32'hDEAD_BEEF, lat, ows, owd, owb);
        chk("ldw_latency", 128'(lat), 128'(3));
        chk("ldw_ben", 128'(owb[104:101]), 128'(4'hF));
        chk("ldw_rdata", 128'(owb[100:69]), 128'(32'hDEAD_BEEF));

        // st.b 0x1003
        run_instr(mk(3'b000, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0000_00A5, 5'd0,
                     32'h0000_1003, 32'h1c00_0004), 0, 0, 0, 0, 32'h0, lat, ows, owd, owb);
        chk("stb_wstrb", 128'(ows), 128'(4'b1000));
        chk("stb_wdata", 128'(owd), 128'(32'hA5A5_A5A5));

        // Misaligned ld.h 0x2001
        run_instr(mk(3'b100, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 32'd0, 5'd6, 32'h0000_2001,
                     32'h1c00_0008), 0, 0, 0, 0, 32'h0, lat, ows, owd, owb);
        chk("ldh_mis_latency", 128'(lat), 128'(1));
        chk("ldh_mis_ben", 128'(owb[104:101]), 128'(4'b0000));

        // addr_ok withheld for 4 cycles
        run_instr(mk(3'b100, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'd0, 5'd9, 32'h0000_3000,
                     32'h1c00_000c), 0, 4, 1, 0, 32'h0BAD_F00D, lat, ows, owd, owb);
        chk("slow_addr_latency", 128'(lat), 128'(8));

        // WB stalls 3 cycles in DONE
        run_instr(mk(3'b100, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 32'd0, 5'd10, 32'h0000_4002,
                     32'h1c00_0010), 0, 0, 0, 3, 32'h1357_9BDF, lat, ows, owd, owb);
        chk("wb_stall_rdata", 128'(owb[100:69]), 128'(32'h1357_9BDF));

        // Reset while waiting for data; late data_ok must be ignored
        @(negedge clk);
        EX_to_MEM_bus   = mk(3'b100, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'd0, 5'd3,
                             32'h0000_1008, 32'h1c00_0014);
        EX_to_MEM_valid = 1'b1;
        @(negedge clk);
        EX_to_MEM_valid   = 1'b0;
        data_sram_addr_ok = 1'b1;
        #1;
        chk("r_mid_req", 128'(data_sram_req), 128'(1'b1));
        @(negedge clk);
        data_sram_addr_ok = 1'b0;
        reset             = 1'b1;
        #1;
        chk("r_mid_wait_data_req", 128'(data_sram_req), 128'(1'b0));
        @(negedge clk);
        reset             = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_5678;
        #1;
        chk("r_mid_wb_valid", 128'(MEM_to_WB_valid), 128'(1'b0));
        chk("r_mid_allow", 128'(MEM_allow_in), 128'(1'b1));
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        chk("r_mid_late_wb_valid", 128'(MEM_to_WB_valid), 128'(1'b0));
        chk("r_mid_late_req", 128'(data_sram_req), 128'(1'b0));
        m_buf = 32'd0;

        // Non-memory op: forwards ALU result and carries the cleared buffer
        run_instr(mk(3'b001, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 5'd7,
                     32'hCAFE_0001, 32'h1c00_0018), 0, 0, 0, 0, 32'h0, lat, ows, owd, owb);
        chk("nonmem_latency", 128'(lat), 128'(1));
        chk("nonmem_rdata", 128'(owb[100:69]), 128'(32'd0));

        for (int i = 0; i < 300; i++) begin
            sel = 2'($urandom_range(0, 2));
            wd  = (sel == 2'd2) ? 2'b10 : sel;
            sel = 2'($urandom_range(0, 2));
            wa  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_instr(mk(3'($urandom), 1'($urandom), 1'($urandom), wd, 1'($urandom),
                         sel == 2'd1, sel == 2'd2, $urandom, wa, $urandom, $urandom),
                      1, 0, 0, 0, 32'h0, lat, ows, owd, owb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-002 SHALL have: EX_to_MEM_bus  in  111  packed MSB->LSB: sel_rf_w_data_valid_stage[3], sel_rf_w_en[1], sel_rf_w_data[1], sel_data_ram_wd[2] (bit1 byte, bit0 half, 00 word), sel_data_ram_extend[1] (1 zero-extend), mem_re[1], mem_we[1], store_data[32], RegFile_w_addr[5], alu_result[32] (address), inst_PC[32].
REQ-003 SHALL have: EX_to_MEM_valid  in  1; MEM_allow_in  out  1; MEM_to_WB_valid  out  1; WB_allow_in  in  1.
REQ-004 SHALL have: MEM_to_WB_bus  out  113  packed: sel_rf_w_data_valid_stage[3], sel_rf_w_en, sel_rf_w_data, sel_data_ram_wd[2], sel_data_ram_extend, data_ram_b_en[4], data_ram_r_data[32], RegFile_w_addr[5], alu_result[32], inst_PC[32].
REQ-005 SHALL have: MEM_to_BY_bus  out  40  packed: RegFile_w_addr[5], fwd_data[32], fwd_data_valid, MEM_valid, sel_rf_w_en.
REQ-006 SHALL have: data_sram_req out 1; data_sram_wr out 1; data_sram_wstrb out 4; data_sram_addr out 32; data_sram_wdata out 32; data_sram_addr_ok in 1; data_sram_data_ok in 1; data_sram_rdata in 32.

Function
REQ-007 Pipeline: MEM_allow_in = ~MEM_valid | (MEM_ready_go & WB_allow_in); MEM_to_WB_valid = MEM_valid & MEM_ready_go.
REQ-008 On clock with MEM_allow_in: MEM_valid <= EX_to_MEM_valid; EX_to_MEM_bus latched into stage register only when EX_to_MEM_valid & MEM_allow_in; otherwise held.
REQ-009 mem_op = MEM_valid & (mem_re | mem_we) & aligned; aligned: word addr[1:0]==00, half addr[0]==0, byte always.
REQ-010 Byte enable from addr[1:0]: byte -> 0001/0010/0100/1000 for 0/1/2/3; half -> 0011 (addr[1]=0) / 1100; word -> 1111; misaligned -> 0000.
REQ-011 data_sram_wstrb = byte enable when mem_we, else 0000; wdata: byte {4{store_data[7:0]}}, half {2{store_data[15:0]}}, word store_data.
REQ-012 data_sram_addr = {alu_result[31:2],2'b00}; data_sram_wr = mem_we.
REQ-013 FSM states IDLE, WAIT_ADDR, WAIT_DATA, DONE; on latching new instr: next = WAIT_ADDR if its mem_op else IDLE.
REQ-014 data_sram_req = (state==WAIT_ADDR); WAIT_ADDR & addr_ok -> WAIT_DATA; req/addr/wdata/wstrb held stable until addr_ok.
REQ-015 WAIT_DATA & data_ok -> DONE, rdata captured into 32-bit buffer; data_ok in any other state ignored.
REQ-016 MEM_ready_go = ~mem_op | (state==DONE); DONE with WB_allow_in & no new instr -> IDLE.
REQ-017 data_ram_r_data output = captured buffer; misaligned/non-memory instrs carry buffer value unchanged (don't care to WB).
REQ-018 Misaligned access: no SRAM request, ready immediately, b_en 0000.
REQ-019 fwd_data = alu_result; fwd_data_valid = MEM_valid & ~sel_rf_w_data & (stage[0]|stage[1]); fwd_data = 0 when RegFile_w_addr==0.
REQ-020 At most one outstanding SRAM transaction; no new request before DONE handed off.

Reset
REQ-021 Reset: MEM_valid 0, state IDLE, stage register 0, buffer 0; req 0, MEM_to_WB_valid 0, MEM_allow_in 1.
REQ-022 Reset mid-transaction abandons it; data_ok arriving after reset ignored (state IDLE).

Verification
REQ-023 ld.w addr 0x1004, addr_ok same cycle as req, data_ok next cycle rdata 0xDEADBEEF -> b_en 1111, r_data 0xDEADBEEF, MEM_to_WB_valid 3 cycles after entry.
REQ-024 st.b addr 0x1003 data 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5, wr 1.
REQ-025 ld.h addr 0x2001 -> no req, b_en 0000, MEM_to_WB_valid next cycle.
REQ-026 addr_ok low 4 cycles -> req/addr stable, MEM_allow_in 0 throughout.
REQ-027 DONE with WB_allow_in 0 for 3 cycles -> bus held, no second req; release -> single handoff.
REQ-028 Reset in WAIT_DATA, data_ok one cycle later -> state stays IDLE, MEM_to_WB_valid 0.
